// File: rtl/cnn_weight_loader.sv
// Streaming weight loader: packs signed elements into feature, bias and FC words and
// drives the CNN write ports, holding each write for WRITE_CYCLES cycles.
module cnn_weight_loader #(
    parameter int unsigned NUM_FEATURES     = 3,
    parameter int unsigned KERNEL_SIZE      = 4,
    parameter int unsigned FLATTENED_LENGTH = 432,
    parameter int unsigned FC_GROUP         = 16,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned WRITE_CYCLES     = 2,
    localparam int unsigned KK       = KERNEL_SIZE * KERNEL_SIZE,
    localparam int unsigned FC_WORDS = (FLATTENED_LENGTH + FC_GROUP - 1) / FC_GROUP,
    localparam int unsigned FEAT_AW  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
    localparam int unsigned FC_AW    = (FC_WORDS > 1) ? $clog2(FC_WORDS) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_loader,
    input  logic                                    start,
    input  logic [1:0]                              load_mode,
    input  logic [DATA_WIDTH-1:0]                   in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [DATA_WIDTH*KK-1:0]                feature_weights_input,
    output logic [FEAT_AW-1:0]                      feature_writeAddr,
    output logic                                    feature_WrEn,
    output logic [DATA_WIDTH*(NUM_FEATURES+1)-1:0]  bias_weights_input,
    output logic                                    bias_WrEn,
    output logic [DATA_WIDTH*FC_GROUP-1:0]          fullyconnected_weights_input,
    output logic [FC_AW-1:0]                        fullyconnected_writeAddr,
    output logic                                    fullyconnected_WrEn,
    output logic                                    busy,
    output logic                                    load_done
);

    localparam int unsigned NB       = NUM_FEATURES + 1;
    localparam int unsigned FW       = DATA_WIDTH * KK;
    localparam int unsigned BW       = DATA_WIDTH * NB;
    localparam int unsigned CW       = DATA_WIDTH * FC_GROUP;
    localparam int unsigned FC_LAST  = FLATTENED_LENGTH - (FC_WORDS - 1) * FC_GROUP;
    localparam int unsigned MAX_A    = (KK > NB) ? KK : NB;
    localparam int unsigned MAX_ELEM = (MAX_A > FC_GROUP) ? MAX_A : FC_GROUP;
    localparam int unsigned CNT_W    = $clog2(MAX_ELEM + 1);
    localparam int unsigned WC_W     = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StFeatFill, StFeatWrite, StBiasFill, StBiasWrite, StFcFill, StFcWrite, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [FEAT_AW-1:0] feat_addr_q, feat_addr_d;
    logic [FC_AW-1:0]   fc_addr_q, fc_addr_d;
    logic [FW-1:0]      feat_word_q, feat_word_d;
    logic [BW-1:0]      bias_word_q, bias_word_d;
    logic [CW-1:0]      fc_word_q, fc_word_d;

    logic               wr_last;
    logic               fc_last_word;
    logic [CNT_W-1:0]   fc_len;

    assign wr_last      = (wcnt_q == WC_W'(WRITE_CYCLES - 1));
    assign fc_last_word = (fc_addr_q == FC_AW'(FC_WORDS - 1));
    assign fc_len       = fc_last_word ? CNT_W'(FC_LAST) : CNT_W'(FC_GROUP);

    assign feature_weights_input        = feat_word_q;
    assign feature_writeAddr            = feat_addr_q;
    assign bias_weights_input           = bias_word_q;
    assign fullyconnected_weights_input = fc_word_q;
    assign fullyconnected_writeAddr     = fc_addr_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        feat_addr_d = feat_addr_q;
        fc_addr_d   = fc_addr_q;
        feat_word_d = feat_word_q;
        bias_word_d = bias_word_q;
        fc_word_d   = fc_word_q;
        in_ready            = 1'b0;
        feature_WrEn        = 1'b1;
        bias_WrEn           = 1'b1;
        fullyconnected_WrEn = 1'b1;
        busy                = (state_q != StIdle);
        load_done           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d      = load_mode;
                    cnt_d       = '0;
                    feat_addr_d = '0;
                    fc_addr_d   = '0;
                    unique case (load_mode)
                        2'b10:   state_d = StBiasFill;
                        2'b11:   state_d = StFcFill;
                        default: state_d = StFeatFill;
                    endcase
                end
            end
            StFeatFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int i = 0; i < KK; i++) begin
                        if (cnt_q == CNT_W'(i)) feat_word_d[FW-1-i*DATA_WIDTH -: DATA_WIDTH] = in_data;
                    end
                    if (cnt_q == CNT_W'(KK - 1)) begin
                        cnt_d   = '0;
                        wcnt_d  = '0;
                        state_d = StFeatWrite;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFeatWrite: begin
                feature_WrEn = 1'b0;
                if (!wr_last) begin
                    wcnt_d = wcnt_q + 1'b1;
                end else if (feat_addr_q != FEAT_AW'(NUM_FEATURES - 1)) begin
                    feat_addr_d = feat_addr_q + 1'b1;
                    state_d     = StFeatFill;
                end else begin
                    state_d = (mode_q == 2'b00) ? StBiasFill : StDone;
                end
            end
            StBiasFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int i = 0; i < NB; i++) begin
                        if (cnt_q == CNT_W'(i)) bias_word_d[BW-1-i*DATA_WIDTH -: DATA_WIDTH] = in_data;
                    end
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        cnt_d   = '0;
                        wcnt_d  = '0;
                        state_d = StBiasWrite;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StBiasWrite: begin
                bias_WrEn = 1'b0;
                if (!wr_last) wcnt_d = wcnt_q + 1'b1;
                else          state_d = (mode_q == 2'b00) ? StFcFill : StDone;
            end
            StFcFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // The final element of the last word also clears the unused low slots.
                    for (int i = 0; i < FC_GROUP; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            fc_word_d[CW-1-i*DATA_WIDTH -: DATA_WIDTH] = in_data;
                        end else if (fc_last_word && cnt_q == fc_len - 1'b1 && CNT_W'(i) > cnt_q) begin
                            fc_word_d[CW-1-i*DATA_WIDTH -: DATA_WIDTH] = '0;
                        end
                    end
                    if (cnt_q == fc_len - 1'b1) begin
                        cnt_d   = '0;
                        wcnt_d  = '0;
                        state_d = StFcWrite;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFcWrite: begin
                fullyconnected_WrEn = 1'b0;
                if (!wr_last) begin
                    wcnt_d = wcnt_q + 1'b1;
                end else if (!fc_last_word) begin
                    fc_addr_d = fc_addr_q + 1'b1;
                    state_d   = StFcFill;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                load_done = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_loader) begin
            state_q     <= StIdle;
            mode_q      <= 2'b00;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            feat_addr_q <= '0;
            fc_addr_q   <= '0;
            feat_word_q <= '0;
            bias_word_q <= '0;
            fc_word_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            feat_addr_q <= feat_addr_d;
            fc_addr_q   <= fc_addr_d;
            feat_word_q <= feat_word_d;
            bias_word_q <= bias_word_d;
            fc_word_q   <= fc_word_d;
        end
    end

endmodule
